sl_tx_arbiter: RTL and testbench

- Shares one serial-line transmitter (ready/enable/data/mode interface) between NUM_REQ independent requesters.
- Arbitrates round-robin, then latches the winner's word and mode and holds them stable for the whole transfer.
- Sequences the transmitter's enable/ready handshake and returns a per-requester completion or error pulse.
- Sits between several register front-ends (APB or internal sources) and the transmitter, all in the transmitter's clock domain.

---
 rtl/sl_pkg.sv | 19 +
 rtl/sl_rr_pick.sv | 38 +++
 rtl/sl_tx_arbiter.sv | 121 ++++++++++++
 tb/tb_sl_tx_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sl_pkg.sv
// Shared serial-line types: transfer mode encoding and tx arbiter states.
// Imported by the arbiter, the transmitter and the APB bridge.
package sl_pkg;

  typedef enum logic [1:0] {
    MODE_8   = 2'b00,
    MODE_16  = 2'b01,
    MODE_32  = 2'b10,
    MODE_INV = 2'b11
  } slMode_t;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    CHECK     = 2'b01,
    WAIT_BUSY = 2'b10,
    WAIT_DONE = 2'b11
  } arbState_t;

endpackage

// File: rtl/sl_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
// SL_ARB_PRIORITY_EN: requester 0 always wins and is excluded from the rotation.
module sl_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] winner
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] rrReq;
  logic [IDX_W-1:0]   idxV;

  always_comb begin
    rrReq  = req;
    idxV   = '0;
    valid  = 1'b0;
    winner = '0;
`ifdef SL_ARB_PRIORITY_EN
    rrReq[0] = 1'b0;
    if (req[0]) begin
      valid  = 1'b1;
      winner = '0;
    end
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      idxV = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!valid && rrReq[idxV]) begin
        valid  = 1'b1;
        winner = idxV;
      end
    end
  end

endmodule

// File: rtl/sl_tx_arbiter.sv
// Round-robin arbiter sharing one serial-line transmitter among NUM_REQ requesters.
// Optional SL_ARB_PRIORITY_EN makes requester 0 a fixed highest-priority source.
module sl_tx_arbiter
  import sl_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 32,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ*2-1:0]        req_mode,
  output logic [NUM_REQ-1:0]          ack,
  output logic [NUM_REQ-1:0]          err,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_idx,
  input  logic                        tx_ready,
  output logic                        tx_enable,
  output logic [DATA_W-1:0]           tx_data,
  output logic [1:0]                  tx_mode
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  arbState_t          state, stateNext;
  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;
  logic               pickValid;
  logic [IDX_W-1:0]   pickIdx;
  logic               doGrant;
  logic               enableNext;
  logic [NUM_REQ-1:0] ackNext, errNext;

  sl_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pickValid),
    .winner (pickIdx)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    doGrant    = 1'b0;
    enableNext = 1'b0;
    ackNext    = '0;
    errNext    = '0;
    case (state)
      IDLE: begin
        if (tx_ready && pickValid) begin
          doGrant   = 1'b1;
          stateNext = CHECK;
        end
      end
      CHECK: begin
        if (tx_mode == MODE_INV) begin
          errNext[grant_idx] = 1'b1;
          stateNext          = IDLE;
        end else begin
          enableNext = 1'b1;
          stateNext  = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!tx_ready) begin
          stateNext = WAIT_DONE;
        end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
          errNext[grant_idx] = 1'b1;
          stateNext          = IDLE;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          ackNext[grant_idx] = 1'b1;
          stateNext          = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Registered outputs; word, mode and winner are captured only on the grant edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= '0;
      cnt       <= '0;
      grant_idx <= '0;
      tx_data   <= '0;
      tx_mode   <= '0;
      tx_enable <= 1'b0;
      ack       <= '0;
      err       <= '0;
      busy      <= 1'b0;
    end else begin
      tx_enable <= enableNext;
      ack       <= ackNext;
      err       <= errNext;
      busy      <= (stateNext != IDLE);
      cnt       <= (state == WAIT_BUSY) ? cnt + 1'b1 : '0;
      if (doGrant) begin
        grant_idx <= pickIdx;
        tx_data   <= req_data[pickIdx*DATA_W +: DATA_W];
        tx_mode   <= req_mode[pickIdx*2 +: 2];
`ifdef SL_ARB_PRIORITY_EN
        if (pickIdx != '0)
          ptr <= (pickIdx == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1) : pickIdx + 1'b1;
`else
        ptr <= (pickIdx == IDX_W'(NUM_REQ - 1)) ? '0 : pickIdx + 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sl_tx_arbiter.sv
// Directed bench for sl_tx_arbiter (default build) with a simple transmitter model.
module tb_sl_tx_arbiter;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [7:0]   req_mode;
  logic [3:0]   ack, err;
  logic         busy;
  logic [1:0]   grant_idx;
  logic         tx_ready;
  logic         tx_enable;
  logic [31:0]  tx_data;
  logic [1:0]   tx_mode;

  // transmitter model controls
  logic txReadyQ;
  int   busyCnt;
  int   busyCycles;
  logic neverBusy;
  logic stuckLow;

  int checkCount = 0;
  int failCount  = 0;

  sl_tx_arbiter #(.NUM_REQ(4), .DATA_W(32), .BUSY_TIMEOUT(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .req_data  (req_data),
    .req_mode  (req_mode),
    .ack       (ack),
    .err       (err),
    .busy      (busy),
    .grant_idx (grant_idx),
    .tx_ready  (tx_ready),
    .tx_enable (tx_enable),
    .tx_data   (tx_data),
    .tx_mode   (tx_mode)
  );

  always #5 clock = ~clock;

  assign tx_ready = txReadyQ & ~stuckLow;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      txReadyQ <= 1'b1;
      busyCnt  <= 0;
    end else if (txReadyQ && tx_enable && !neverBusy) begin
      txReadyQ <= 1'b0;
      busyCnt  <= busyCycles;
    end else if (!txReadyQ) begin
      if (busyCnt <= 1) txReadyQ <= 1'b1;
      else              busyCnt  <= busyCnt - 1;
    end
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitAck(input string tag, input logic [3:0] expAck, input int budget);
    int n;
    n = 0;
    while (ack == 4'b0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkVal(tag, {err, ack}, {4'b0, expAck});
  endtask

  initial begin
    int n;
    int errAt;
    int enCount;
    int nAck;
    logic [3:0] seen;
    logic [1:0] fairExp [8];
    fairExp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    reset_n    = 1'b0;
    req        = '0;
    req_data   = '0;
    req_mode   = '0;
    busyCycles = 40;
    neverBusy  = 1'b0;
    stuckLow   = 1'b0;

    // reset state
    repeat (2) @(negedge clock);
    checkVal("rst_ctrl", {ack, err, busy, grant_idx, tx_enable, tx_mode}, '0);
    checkVal("rst_data", tx_data, '0);
    reset_n = 1'b1;
    @(negedge clock);

    // single request, data hold while busy
    req_data[31:0] = 32'hA5A5_1234;
    req_mode[1:0]  = 2'b10;
    req            = 4'b0001;
    @(negedge clock);
    checkVal("t1_grant", {busy, grant_idx, tx_enable}, {1'b1, 2'd0, 1'b0});
    @(negedge clock);
    checkVal("t1_enable", tx_enable, 1'b1);
    checkVal("t1_data", {tx_mode, tx_data}, {2'b10, 32'hA5A5_1234});
    req_data[31:0] = 32'hDEAD_BEEF;
    req_mode[1:0]  = 2'b00;
    @(negedge clock);
    checkVal("t1_en_once", tx_enable, 1'b0);
    n = 0;
    while (tx_ready && n < 10) begin @(negedge clock); n++; end
    checkVal("t1_txbusy", tx_ready, 1'b0);
    n = 0;
    while (!tx_ready && n < 100) begin @(negedge clock); n++; end
    checkVal("t1_ack_early", ack, 4'b0);
    @(negedge clock);
    checkVal("t1_ack", ack, 4'b0001);
    checkVal("t1_hold", {tx_mode, tx_data}, {2'b10, 32'hA5A5_1234});
    req = 4'b0000;
    @(negedge clock);
    checkVal("t1_ack_pulse", {busy, ack}, '0);

    // fairness: pointer is 1 after serving requester 0
    busyCycles = 3;
    req_data   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    req_mode   = 8'b10_10_10_10;
    req        = 4'b1111;
    nAck = 0; enCount = 0; n = 0; seen = '0;
    while (nAck < 8 && n < 400) begin
      @(negedge clock);
      n++;
      if (tx_enable) enCount++;
      seen = seen | err;
      if (ack != 4'b0) begin
        checkVal("fair_ack", {grant_idx, ack}, {fairExp[nAck], 4'b0001 << fairExp[nAck]});
        nAck++;
        if (nAck == 8) req = 4'b0000;
      end
    end
    checkVal("fair_count", {nAck[7:0], enCount[7:0], seen}, {8'd8, 8'd8, 4'b0});

    // invalid mode on requester 2
    @(negedge clock);
    req_mode[5:4] = 2'b11;
    req           = 4'b0100;
    @(negedge clock);
    checkVal("inv_grant", {grant_idx, err, tx_enable}, {2'd2, 4'b0, 1'b0});
    @(negedge clock);
    checkVal("inv_err", {err, tx_enable}, {4'b0100, 1'b0});
    req = 4'b0000;
    req_mode[5:4] = 2'b10;
    @(negedge clock);
    checkVal("inv_done", {busy, err, tx_enable}, '0);
    req = 4'b1111;
    @(negedge clock);
    checkVal("inv_ptr3", grant_idx, 2'd3);
    waitAck("inv_next_ack", 4'b1000, 100);
    req = 4'b0000;
    @(negedge clock);

    // busy timeout: transmitter never reacts
    neverBusy = 1'b1;
    req       = 4'b0010;
    @(negedge clock);
    checkVal("to_grant", grant_idx, 2'd1);
    @(negedge clock);
    checkVal("to_enable", tx_enable, 1'b1);
    errAt = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clock);
      if (err != 4'b0 && errAt == 0) begin
        errAt = k;
        checkVal("to_err", {err, ack}, {4'b0010, 4'b0});
        req = 4'b0000;
      end
    end
    checkVal("to_latency", errAt, 16);
    neverBusy = 1'b0;
    req       = 4'b0010;
    waitAck("to_recover", 4'b0010, 100);
    req = 4'b0000;
    @(negedge clock);

    // tx_ready stuck low in IDLE
    stuckLow = 1'b1;
    req      = 4'b0001;
    seen     = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      seen = seen | ack | err | {3'b0, busy | tx_enable};
    end
    checkVal("stuck_idle", seen, 4'b0);
    stuckLow = 1'b0;
    waitAck("stuck_release", 4'b0001, 100);
    req = 4'b0000;
    @(negedge clock);

    // reset in WAIT_DONE, then pointer restarts at 0
    busyCycles = 40;
    req        = 4'b0010;
    n = 0;
    while (tx_ready && n < 10) begin @(negedge clock); n++; end
    repeat (2) @(negedge clock);
    checkVal("rm_busy", {busy, grant_idx}, {1'b1, 2'd1});
    reset_n = 1'b0;
    req     = 4'b0000;
    #1;
    checkVal("rm_async", {ack, err, busy, grant_idx, tx_enable, tx_mode}, '0);
    seen = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      seen = seen | ack | err;
    end
    checkVal("rm_no_ack", {seen, tx_data}, '0);
    reset_n = 1'b1;
    req     = 4'b1001;
    @(negedge clock);
    checkVal("rm_ptr0", {busy, grant_idx}, {1'b1, 2'd0});
    waitAck("rm_ack0", 4'b0001, 100);
    req = 4'b1000;
    @(negedge clock);
    waitAck("rm_ack3", 4'b1000, 100);
    req = 4'b0000;
    @(negedge clock);
    checkVal("final_idle", {busy, ack, err}, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
